// File: rtl/apb_master_bridge_if.sv
// Bundle of the command, response and APB signals of apb_master_bridge.
// master: the bridge's view (drives cmd_ready, rsp_*, APB request signals).
// slave:  the surrounding environment's view (command source, APB slave).
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, addr, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, addr, pwdata,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB master bridge, one transfer at a time.
// Optional build macro APB_TIMEOUT_EN: abandons an ACCESS phase that has
// waited TIMEOUT_CYCLES cycles without pready and reports it as an error.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | cmd_ready high; accepts a command and latches it onto APB
// ST_SETUP  | psel high, penable low; always one cycle
// ST_ACCESS | psel and penable high; waits for pready (or timeout)
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                resetn,
    apb_master_bridge_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    // Next-state and registered-output decode for the transfer sequence.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        addr_d      = addr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (bus.cmd_valid) begin
                    pwrite_d = bus.cmd_write;
                    addr_d   = bus.cmd_addr;
                    // Reads present zero on pwdata rather than stale data.
                    pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                    psel_d   = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                if (bus.pready) begin
                    state_d     = ST_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                end
`ifdef APB_TIMEOUT_EN
                // This is the TIMEOUT_CYCLES-th ACCESS cycle without pready.
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = ST_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
                addr_d    = '0;
                pwdata_d  = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            addr_q      <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            addr_q      <= addr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    // ACCESS-phase wait counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.addr      = addr_q;
    assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed cases plus random
// commands, a behavioural APB slave with its own memory, and a monitor
// that checks APB phases, response data and latency in cycles.
module tb_apb_master_bridge;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int T  = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;   // expected pwdata (0 on reads)
        logic [DW-1:0] rd;   // expected rsp_rdata
        logic          err;
        int            waits; // pready-low ACCESS cycles the bridge sits through
    } exp_t;

    typedef struct {
        int   waits;
        logic err;
    } slv_t;

    exp_t exp_q[$];
    slv_t slv_q[$];
    int   acc_q[$];

    logic [DW-1:0] model_mem [32];
    logic [DW-1:0] slave_mem [32];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_sent   = 0;
    int n_rsp    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: response decided from the command and slave behaviour.
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int waits, input logic err);
        exp_t e;
        slv_t s;
        int   bound;
        e.wr    = wr;
        e.a     = a;
        e.wd    = wr ? wd : '0;
        e.rd    = wr ? '0 : model_mem[a];
        e.err   = err;
        e.waits = waits;
`ifdef APB_TIMEOUT_EN
        if (waits >= T) begin
            e.err   = 1'b1;
            e.rd    = '0;
            e.waits = T - 1;
        end
`endif
        if (wr && !e.err) model_mem[a] = wd;
        s.waits = waits;
        s.err   = err;
        slv_q.push_back(s);
        exp_q.push_back(e);
        n_sent++;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        bound = 0;
        do begin
            @(negedge clk);
            bound++;
        end while (!bus.cmd_ready && bound < 200);
        check("cmd_accept", bus.cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Behavioural APB slave: garbage on ignored cycles, scheduled pready.
    initial begin
        int   cnt;
        slv_t s;
        cnt = 0;
        s.waits = 0;
        s.err = 1'b0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.prdata  = $urandom;
            bus.pslverr = 1'($urandom_range(0, 1));
            bus.pready  = 1'($urandom_range(0, 1));
            if (!resetn) begin
                bus.pready = 1'b0;
            end else if (bus.psel && !bus.penable) begin
                check("slave_setup_has_cmd", 64'(slv_q.size() > 0), 64'd1);
                if (slv_q.size() > 0) s = slv_q.pop_front();
                cnt = s.waits;
            end else if (bus.psel && bus.penable) begin
                if (cnt > 0) begin
                    bus.pready = 1'b0;
                    cnt--;
                end else begin
                    bus.pready  = 1'b1;
                    bus.pslverr = s.err;
                    bus.prdata  = bus.pwrite ? DW'($urandom) : slave_mem[bus.addr];
                    if (bus.pwrite && !s.err) slave_mem[bus.addr] = bus.pwdata;
                end
            end
        end
    end

    // Monitor: APB phase checks and response scoreboard.
    initial begin
        int            psel_n;
        int            pen_n;
        int            a;
        logic [DW-1:0] last_rd;
        logic          last_err;
        exp_t          e;
        psel_n = 0;
        pen_n = 0;
        last_rd = '0;
        last_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                psel_n = 0;
                pen_n = 0;
                last_rd = '0;
                last_err = 1'b0;
            end else begin
                if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
                if (bus.psel) begin
                    psel_n++;
                    if (bus.penable) pen_n++;
                    check("penable_phase", bus.penable, (psel_n == 1) ? 1'b0 : 1'b1);
                    check("psel_has_cmd", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q[0];
                        check("apb_addr", bus.addr, e.a);
                        check("apb_pwrite", bus.pwrite, e.wr);
                        check("apb_pwdata", bus.pwdata, e.wd);
                    end
                end else begin
                    check("penable_without_psel", bus.penable, 1'b0);
                end
                if (bus.rsp_valid) begin
                    check("rsp_expected", 64'(exp_q.size() > 0 && acc_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0 && acc_q.size() > 0) begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        n_rsp++;
                        check("rsp_rdata", bus.rsp_rdata, e.rd);
                        check("rsp_err", bus.rsp_err, e.err);
                        check("rsp_latency", 64'(cyc - a), 64'(3 + e.waits));
                        check("psel_cycles", 64'(psel_n), 64'(2 + e.waits));
                        check("penable_cycles", 64'(pen_n), 64'(1 + e.waits));
                        check("cmd_ready_on_rsp", bus.cmd_ready, 1'b1);
                    end
                    last_rd = bus.rsp_rdata;
                    last_err = bus.rsp_err;
                    psel_n = 0;
                    pen_n = 0;
                end else begin
                    check("rsp_rdata_hold", bus.rsp_rdata, last_rd);
                    check("rsp_err_hold", bus.rsp_err, last_err);
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_psel"}, bus.psel, 1'b0);
        check({tag, "_penable"}, bus.penable, 1'b0);
        check({tag, "_pwrite"}, bus.pwrite, 1'b0);
        check({tag, "_addr"}, bus.addr, '0);
        check({tag, "_pwdata"}, bus.pwdata, '0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        check({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, '0);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    endtask

    initial begin
        int bound;
        for (int i = 0; i < 32; i++) begin
            model_mem[i] = '0;
            slave_mem[i] = '0;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        #3;
        check_idle_outputs("reset");
        #19;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Directed: zero-wait write, 2-wait read, slave error, back-to-back.
        send(1'b1, 5'h03, 32'hDEADBEEF, 0, 1'b0);
        send(1'b0, 5'h03, 32'h0, 2, 1'b0);
        send(1'b0, 5'h1F, 32'h0, 0, 1'b1);
        send(1'b0, 5'h1F, 32'h0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send(1'b1, 5'h00, 32'h11110000, 0, 1'b0);
        send(1'b1, 5'h01, 32'h22221111, 0, 1'b0);
        send(1'b1, 5'h02, 32'h33332222, 0, 1'b0);
        send(1'b0, 5'h01, 32'h0, 1, 1'b0);

        // Long waits: abandoned with the timeout feature, completed without it.
        send(1'b0, 5'h02, 32'h0, 20, 1'b0);
        send(1'b1, 5'h05, 32'hCAFEF00D, 20, 1'b0);
        send(1'b0, 5'h02, 32'h0, T - 1, 1'b0);
        send(1'b0, 5'h05, 32'h0, 0, 1'b0);

        // Reset in the middle of an ACCESS wait.
        repeat (4) @(posedge clk);
        #1;
        send(1'b0, 5'h01, 32'h0, 8, 1'b0);
        @(posedge clk);
        #2;
        check("abort_penable", bus.penable, 1'b1);
        check("abort_pready", bus.pready, 1'b0);
        resetn = 1'b0;
        #1;
        check_idle_outputs("abort");
        exp_q.delete();
        acc_q.delete();
        slv_q.delete();
        n_sent--;
        @(negedge clk);
        #2;
        resetn = 1'b1;
        #1;
        check("post_reset_cmd_ready", bus.cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        send(1'b0, 5'h02, 32'h0, 0, 1'b0);

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            int g;
            int w;
            w = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 20));
            send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom),
                 w, ($urandom_range(0, 7) == 0));
            g = $urandom_range(0, 2);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end

        bound = 0;
        while (exp_q.size() > 0 && bound < 200) begin
            @(posedge clk);
            bound++;
        end
        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("rsp_count", 64'(n_rsp), 64'(n_sent));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command interface into APB transfers; it drives the register-bank APB slave directly.
- Issues one transfer at a time through IDLE -> SETUP -> ACCESS.
- Holds all APB outputs stable until the slave returns pready.
- Returns read data and the error status as a single-cycle response pulse.

Parameters:
ADDR_WIDTH, 5, width of cmd_addr and addr (32-word slave map)
DATA_WIDTH, 32, width of all data buses
TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait cycles before abort (used only with APB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  target word address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle pulse when a transfer completes
rsp_rdata  output  DATA_WIDTH  read data; valid with rsp_valid on reads
rsp_err  output  1  pslverr (or timeout) status; valid with rsp_valid
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
addr  output  ADDR_WIDTH  APB address
pwdata  output  DATA_WIDTH  APB write data
pready  input  1  slave ready
pslverr  input  1  slave error, sampled only with pready
prdata  input  DATA_WIDTH  slave read data, sampled only with pready

Behaviour:
- All outputs are registered except cmd_ready, which is a decode of the state.
- Reset (asynchronous, resetn low):
  - state = IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_err = 0.
  - addr, pwdata, rsp_rdata = 0.
- Reset asserted mid-transfer aborts immediately. No response is issued for the aborted command.
- IDLE:
  - cmd_ready = 1; psel = 0, penable = 0.
  - On cmd_valid: latch cmd_write -> pwrite, cmd_addr -> addr.
  - pwdata = cmd_wdata on a write; pwdata = 0 on a read.
  - Next state SETUP.
- SETUP (exactly 1 cycle):
  - psel = 1, penable = 0, cmd_ready = 0.
  - Next state ACCESS unconditionally.
- ACCESS:
  - psel = 1, penable = 1.
  - addr, pwrite, pwdata held constant.
  - Remain in ACCESS while pready = 0 (unbounded wait states, unless APB_TIMEOUT_EN is defined).
  - On pready = 1, the next cycle:
    - State = IDLE; psel = 0, penable = 0.
    - rsp_valid = 1 for exactly one cycle; rsp_err = pslverr.
    - rsp_rdata = prdata on a read; rsp_rdata = 0 on a write.
- Latency:
  - Command accept to psel rising: 1 cycle.
  - Zero-wait-state transfer: accept edge to rsp_valid is 3 cycles.
  - Each wait state adds 1 cycle.
- Back-to-back:
  - cmd_ready is high in the same cycle rsp_valid pulses (state is IDLE).
  - A new command may be accepted there, giving one transfer per 3 cycles minimum.
  - psel deasserts for at least 1 cycle between transfers.
- Response interface:
  - No backpressure; the consumer must sample rsp_* on the rsp_valid cycle.
  - rsp_rdata and rsp_err hold their values until the next response.
- Slave inputs:
  - pready, pslverr and prdata are ignored in IDLE and SETUP.
  - pslverr is ignored in ACCESS unless pready = 1.
- Address: no range checking; addr is passed through at ADDR_WIDTH bits.
- Illegal state encodings recover to IDLE with all APB outputs 0.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - A counter clears on SETUP->ACCESS entry and increments each ACCESS cycle with pready = 0.
  - If the counter reaches TIMEOUT_CYCLES with pready still 0:
    - The transfer is abandoned: next cycle state = IDLE, psel = 0, penable = 0.
    - rsp_valid = 1 with rsp_err = 1 and rsp_rdata = 0.
  - pready arriving in the same cycle the limit is reached takes priority: normal completion.
- APB_TIMEOUT_EN undefined: no counter logic exists, and ACCESS waits indefinitely for pready.

Test Plan:
- Write, zero wait states: cmd_write = 1, cmd_addr = 5'h03, cmd_wdata = 32'hDEADBEEF, pready tied high in ACCESS -> psel high 2 cycles, penable high 1 cycle, addr = 3, pwdata = DEADBEEF; rsp_valid 3 cycles after accept with rsp_err = 0.
- Read with 2 wait states: cmd_addr = 5'h03, pready low 2 ACCESS cycles, then high with prdata = 32'hDEADBEEF -> signals stable throughout ACCESS; rsp_rdata = DEADBEEF, rsp_valid 5 cycles after accept.
- Slave error: read addr 5'h1F, pready = 1 with pslverr = 1 -> rsp_valid = 1, rsp_err = 1; next transfer with pslverr = 0 returns rsp_err = 0.
- Back-to-back: cmd_valid held high with writes to addr 0, 1, 2 -> three transfers, each 3 cycles; psel low exactly 1 cycle between transfers; three rsp_valid pulses.
- Reset mid-ACCESS: assert resetn = 0 while penable = 1 and pready = 0 -> all outputs 0 asynchronously, no rsp_valid; after release cmd_ready = 1 and a fresh read completes normally.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, pready stuck 0 -> psel drops after 16 ACCESS cycles, rsp_valid = 1 with rsp_err = 1 and rsp_rdata = 0; repeat with pready rising on the 16th cycle -> normal completion, rsp_err = 0.
